instenc_stream: RTL

//  Inverse of the debug mnemonic decoder: receives an ASCII MIPS mnemonic one byte per handshake.

---
 rtl/instenc_stream.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/instenc_stream.sv
// instenc_stream: assembles one MIPS instruction word from an ASCII mnemonic
// streamed a byte at a time plus operand fields presented on side ports.
module instenc_stream #(
   parameter int MAX_CHARS  = 7,
   parameter int FOLD_LOWER = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ch_valid,
   input  logic [7:0]  ch_data,
   output logic        ch_ready,
   input  logic [4:0]  op_rs,
   input  logic [4:0]  op_rt,
   input  logic [4:0]  op_rd,
   input  logic [4:0]  op_sa,
   input  logic [15:0] op_imm,
   input  logic [25:0] op_target,
   output logic        ins_valid,
   output logic [31:0] ins_word,
   output logic        ins_err,
   input  logic        ins_ready
);

   localparam int NAME_W = 8 * MAX_CHARS;
   localparam int CNT_W  = $clog2(MAX_CHARS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHARS);

   typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, ENCODE, OUTPUT} state_t;

   state_t             state, state_nxt;
   logic [NAME_W-1:0]  name;
   logic [CNT_W-1:0]   cnt;
   logic               ovf;
   logic [4:0]         lat_rs, lat_rt, lat_rd, lat_sa;
   logic [15:0]        lat_imm;
   logic [25:0]        lat_target;
   logic [7:0]         ch_fold;
   logic               is_term;
   logic               ch_acc;
   logic               term_acc;

   // R-type field packing
   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sa, fn};
   endfunction

   // I-type field packing (also used for REGIMM with the code in the rt slot)
   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Mnemonic lookup; returns {err, word}. Shift amount only reaches the word for SLL/SRL/SRA.
   function automatic logic [32:0] encode(input logic [NAME_W-1:0] nm, input logic of,
                                          input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sa,
                                          input logic [15:0] imm, input logic [25:0] tgt);
      logic [31:0] w;
      logic        e;
      w = 32'h0;
      e = 1'b0;
      if (of) begin
         e = 1'b1;
      end else begin
         case (nm)
            NAME_W'("SLL"):     w = rtype(rs, rt, rd, sa, 6'h00);
            NAME_W'("SRL"):     w = rtype(rs, rt, rd, sa, 6'h02);
            NAME_W'("SRA"):     w = rtype(rs, rt, rd, sa, 6'h03);
            NAME_W'("SLLV"):    w = rtype(rs, rt, rd, 5'h00, 6'h04);
            NAME_W'("SRLV"):    w = rtype(rs, rt, rd, 5'h00, 6'h06);
            NAME_W'("SRAV"):    w = rtype(rs, rt, rd, 5'h00, 6'h07);
            NAME_W'("JR"):      w = rtype(rs, rt, rd, 5'h00, 6'h08);
            NAME_W'("JALR"):    w = rtype(rs, rt, rd, 5'h00, 6'h09);
            NAME_W'("SYSCALL"): w = rtype(rs, rt, rd, 5'h00, 6'h0C);
            NAME_W'("BREAK"):   w = rtype(rs, rt, rd, 5'h00, 6'h0D);
            NAME_W'("MFHI"):    w = rtype(rs, rt, rd, 5'h00, 6'h10);
            NAME_W'("MTHI"):    w = rtype(rs, rt, rd, 5'h00, 6'h11);
            NAME_W'("MFLO"):    w = rtype(rs, rt, rd, 5'h00, 6'h12);
            NAME_W'("MTLO"):    w = rtype(rs, rt, rd, 5'h00, 6'h13);
            NAME_W'("MULT"):    w = rtype(rs, rt, rd, 5'h00, 6'h18);
            NAME_W'("MULTU"):   w = rtype(rs, rt, rd, 5'h00, 6'h19);
            NAME_W'("DIV"):     w = rtype(rs, rt, rd, 5'h00, 6'h1A);
            NAME_W'("DIVU"):    w = rtype(rs, rt, rd, 5'h00, 6'h1B);
            NAME_W'("ADD"):     w = rtype(rs, rt, rd, 5'h00, 6'h20);
            NAME_W'("ADDU"):    w = rtype(rs, rt, rd, 5'h00, 6'h21);
            NAME_W'("SUB"):     w = rtype(rs, rt, rd, 5'h00, 6'h22);
            NAME_W'("SUBU"):    w = rtype(rs, rt, rd, 5'h00, 6'h23);
            NAME_W'("AND"):     w = rtype(rs, rt, rd, 5'h00, 6'h24);
            NAME_W'("OR"):      w = rtype(rs, rt, rd, 5'h00, 6'h25);
            NAME_W'("XOR"):     w = rtype(rs, rt, rd, 5'h00, 6'h26);
            NAME_W'("NOR"):     w = rtype(rs, rt, rd, 5'h00, 6'h27);
            NAME_W'("SLT"):     w = rtype(rs, rt, rd, 5'h00, 6'h2A);
            NAME_W'("SLTU"):    w = rtype(rs, rt, rd, 5'h00, 6'h2B);
            NAME_W'("BEQ"):     w = itype(6'h04, rs, rt, imm);
            NAME_W'("BNE"):     w = itype(6'h05, rs, rt, imm);
            NAME_W'("BLEZ"):    w = itype(6'h06, rs, rt, imm);
            NAME_W'("BGTZ"):    w = itype(6'h07, rs, rt, imm);
            NAME_W'("ADDI"):    w = itype(6'h08, rs, rt, imm);
            NAME_W'("ADDIU"):   w = itype(6'h09, rs, rt, imm);
            NAME_W'("SLTI"):    w = itype(6'h0A, rs, rt, imm);
            NAME_W'("SLTIU"):   w = itype(6'h0B, rs, rt, imm);
            NAME_W'("ANDI"):    w = itype(6'h0C, rs, rt, imm);
            NAME_W'("ORI"):     w = itype(6'h0D, rs, rt, imm);
            NAME_W'("XORI"):    w = itype(6'h0E, rs, rt, imm);
            NAME_W'("LUI"):     w = itype(6'h0F, 5'h00, rt, imm);
            NAME_W'("LB"):      w = itype(6'h20, rs, rt, imm);
            NAME_W'("LH"):      w = itype(6'h21, rs, rt, imm);
            NAME_W'("LW"):      w = itype(6'h23, rs, rt, imm);
            NAME_W'("LBU"):     w = itype(6'h24, rs, rt, imm);
            NAME_W'("LHU"):     w = itype(6'h25, rs, rt, imm);
            NAME_W'("SB"):      w = itype(6'h28, rs, rt, imm);
            NAME_W'("SH"):      w = itype(6'h29, rs, rt, imm);
            NAME_W'("SW"):      w = itype(6'h2B, rs, rt, imm);
            NAME_W'("BLTZ"):    w = itype(6'h01, rs, 5'h00, imm);
            NAME_W'("BGEZ"):    w = itype(6'h01, rs, 5'h01, imm);
            NAME_W'("BLTZAL"):  w = itype(6'h01, rs, 5'h10, imm);
            NAME_W'("BGEZAL"):  w = itype(6'h01, rs, 5'h11, imm);
            NAME_W'("J"):       w = {6'h02, tgt};
            NAME_W'("JAL"):     w = {6'h03, tgt};
            NAME_W'("MFC0"):    w = {6'h10, 5'h00, rt, rd, 11'h000};
            NAME_W'("MTC0"):    w = {6'h10, 5'h04, rt, rd, 11'h000};
            NAME_W'("ERET"):    w = 32'h42000018;
            NAME_W'("NOP"):     w = 32'h00000000;
            default:            e = 1'b1;
         endcase
      end
      return {e, w};
   endfunction

   // Case folding and terminator detection on the incoming byte
   always_comb begin
      ch_fold = ch_data;
      if (FOLD_LOWER != 0 && ch_data >= 8'h61 && ch_data <= 8'h7A)
         ch_fold = ch_data - 8'h20;
      is_term  = (ch_data == 8'h00) || (ch_data == 8'h20) || (ch_data == 8'h0A);
      ch_acc   = ch_valid && ch_ready;
      term_acc = ch_acc && is_term && (state == COLLECT || state == DRAIN);
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (ch_acc && !is_term) state_nxt = COLLECT;
         COLLECT: if (ch_acc) begin
                     if (is_term)             state_nxt = ENCODE;
                     else if (cnt == CNT_MAX) state_nxt = DRAIN;
                  end
         DRAIN:   if (ch_acc && is_term) state_nxt = ENCODE;
         ENCODE:  state_nxt = OUTPUT;
         OUTPUT:  if (ins_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register with registered handshake outputs derived from the next state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ch_ready  <= 1'b0;
         ins_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         ch_ready  <= (state_nxt == IDLE) || (state_nxt == COLLECT) || (state_nxt == DRAIN);
         ins_valid <= (state_nxt == OUTPUT);
      end
   end

   // Mnemonic collector: right-aligned shift register, length count and overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         name <= '0;
         cnt  <= '0;
         ovf  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (ch_acc && !is_term) begin
                     name <= {{(NAME_W-8){1'b0}}, ch_fold};
                     cnt  <= CNT_W'(1);
                  end
            COLLECT: if (ch_acc && !is_term) begin
                     if (cnt < CNT_MAX) begin
                        name <= {name[NAME_W-9:0], ch_fold};
                        cnt  <= cnt + 1'b1;
                     end else begin
                        ovf <= 1'b1;
                     end
                  end
            OUTPUT: if (ins_ready) begin
                     name <= '0;
                     cnt  <= '0;
                     ovf  <= 1'b0;
                  end
            default: ;
         endcase
      end
   end

   // Operand capture on the accepted terminator
   always_ff @(posedge clk) begin
      if (term_acc) begin
         lat_rs     <= op_rs;
         lat_rt     <= op_rt;
         lat_rd     <= op_rd;
         lat_sa     <= op_sa;
         lat_imm    <= op_imm;
         lat_target <= op_target;
      end
   end

   // Encode stage: word and error registered once, then held through the output handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ins_word <= 32'h0;
         ins_err  <= 1'b0;
      end else if (state == ENCODE) begin
         {ins_err, ins_word} <= encode(name, ovf, lat_rs, lat_rt, lat_rd, lat_sa,
                                       lat_imm, lat_target);
      end
   end

endmodule
